// File: rtl/wr_fifo_ctrl.sv
// Write-side pointer/flag controller for a dual-clock FIFO; wr_acc and flags are combinational, pointers update 1 cycle after wr_acc.
// Backpressure: writes are refused (wr_acc=0) while full, which also sets the sticky overflow flag.
module wr_fifo_ctrl #(
    parameter int ADDR_WDTH = 4,
    parameter int AFULL_LVL = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sync_rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_WDTH-1:0] rd_ptr_gray,
    input  logic                 ovf_clr,
    output logic [ADDR_WDTH-1:0] wr_ptr_gray,
    output logic [ADDR_WDTH-1:0] wr_ptr_bin,
    output logic                 wr_acc,
    output logic                 full,
    output logic                 almost_full,
    output logic [ADDR_WDTH-1:0] wr_level,
    output logic                 overflow
);

    localparam logic [ADDR_WDTH-1:0] PTR_ONE   = {{(ADDR_WDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WDTH-1:0] AFULL_THR = AFULL_LVL[ADDR_WDTH-1:0];

    logic [ADDR_WDTH-1:0] rd_ptr_bin;
    logic [ADDR_WDTH-1:0] wr_ptr_nxt;
    logic [ADDR_WDTH-1:0] wr_gray_nxt;

    // Each binary bit is the XOR of its Gray bit and all Gray bits above it.
    always_comb begin
        rd_ptr_bin = '0;
        for (int j = 0; j < ADDR_WDTH; j++) begin
            rd_ptr_bin[j] = ^(rd_ptr_gray >> j);
        end
    end

    assign wr_ptr_nxt  = wr_ptr_bin + PTR_ONE;
    assign wr_gray_nxt = wr_ptr_nxt ^ (wr_ptr_nxt >> 1);

    assign full        = (wr_ptr_nxt == rd_ptr_bin);
    assign wr_level    = wr_ptr_bin - rd_ptr_bin;
    assign almost_full = (wr_level >= AFULL_THR);
    assign wr_acc      = wr_en & ~full;

    // Gray pointer is registered from the next binary value so it never glitches across domains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_bin  <= '0;
            wr_ptr_gray <= '0;
            overflow    <= 1'b0;
        end else if (!sync_rst_n) begin
            wr_ptr_bin  <= '0;
            wr_ptr_gray <= '0;
            overflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_bin  <= wr_ptr_nxt;
                wr_ptr_gray <= wr_gray_nxt;
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
